// File: rtl/pw_verify_pkg.sv
// Shared types and width helpers for the password verification engine and
// its companion blocks (password change, keypad path).
package pw_verify_pkg;

  typedef enum logic [1:0] {IDLE, OPEN, ALARM, LOCKOUT} state_t;

  localparam int BCD_DIGIT_W = 4;

  // Width needed to hold values 0..n-1, never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/pw_verify_if.sv
// Keypad/password/actuator signal bundle for pw_verify. The master side is
// the keypad/control path, the slave side is the verification engine.
interface pw_verify_if #(
  parameter int DIGITS    = 4,
  parameter int N_PW      = 2,
  parameter int MAX_TRIES = 5
);
  localparam int W  = pw_verify_pkg::BCD_DIGIT_W * DIGITS;
  localparam int IW = pw_verify_pkg::idx_w(N_PW + 1);
  localparam int CW = pw_verify_pkg::idx_w(MAX_TRIES + 1);

  logic                STAR;
  logic [W-1:0]        DISPLAY;
  logic [N_PW*W-1:0]   PW;
  logic [W-1:0]        PW_TEMP;
  logic                PW_TEMP_VALID;
  logic                CLOSE_SENSOR;
  logic                ALERT_OFF;
  logic                CORRECT;
  logic                ALERT;
  logic                LOCKED_OUT;
  logic                PW_TEMP_RESET;
  logic [IW-1:0]       MATCH_IDX;
  logic [CW-1:0]       WRONG_CNT;

  modport master (
    output STAR, DISPLAY, PW, PW_TEMP, PW_TEMP_VALID, CLOSE_SENSOR, ALERT_OFF,
    input  CORRECT, ALERT, LOCKED_OUT, PW_TEMP_RESET, MATCH_IDX, WRONG_CNT
  );

  modport slave (
    input  STAR, DISPLAY, PW, PW_TEMP, PW_TEMP_VALID, CLOSE_SENSOR, ALERT_OFF,
    output CORRECT, ALERT, LOCKED_OUT, PW_TEMP_RESET, MATCH_IDX, WRONG_CNT
  );
endinterface

// File: rtl/pw_match.sv
// Combinational password comparator: one equality per permanent slot plus
// the armed temporary password. Lowest-index permanent hit wins.
module pw_match
  import pw_verify_pkg::*;
#(
  parameter  int DIGITS = 4,
  parameter  int N_PW   = 2,
  localparam int W      = BCD_DIGIT_W * DIGITS,
  localparam int IW     = idx_w(N_PW + 1)
) (
  input  logic [W-1:0]      display,
  input  logic [N_PW*W-1:0] pw,
  input  logic [W-1:0]      pw_temp,
  input  logic              pw_temp_valid,
  output logic              perm_hit,
  output logic              temp_hit,
  output logic [IW-1:0]     hit_idx
);

  logic [N_PW-1:0] slot_eq;

  for (genvar k = 0; k < N_PW; k++) begin : g_slot
    assign slot_eq[k] = (pw[k*W +: W] == display);
  end

  // Scan downward so the lowest matching slot is the last one written.
  always_comb begin
    hit_idx = '0;
    for (int k = N_PW - 1; k >= 0; k--)
      if (slot_eq[k]) hit_idx = IW'(k);
  end

  assign perm_hit = |slot_eq;
  assign temp_hit = pw_temp_valid && (pw_temp == display);

endmodule

// File: rtl/pw_verify.sv
// Door-lock password verification FSM: match, consecutive-failure count,
// alarm and timed lockout after acknowledge.
module pw_verify
  import pw_verify_pkg::*;
#(
  parameter int DIGITS         = 4,
  parameter int N_PW           = 2,
  parameter int MAX_TRIES      = 5,
  parameter int LOCKOUT_CYCLES = 1000
) (
  input logic        CLK,
  input logic        RST_N,
  pw_verify_if.slave bus
);

  localparam int IW = idx_w(N_PW + 1);
  localparam int CW = idx_w(MAX_TRIES + 1);
  localparam int LW = idx_w(LOCKOUT_CYCLES + 1);

  logic          perm_hit, temp_hit;
  logic [IW-1:0] hit_idx;

  state_t        state, state_nx;
  logic [CW-1:0] wrong_cnt, wrong_nx;
  logic [IW-1:0] match_idx, match_nx;
  logic [LW-1:0] lock_cnt, lock_nx;
  logic          temp_rst, temp_rst_nx;

  pw_match #(.DIGITS(DIGITS), .N_PW(N_PW)) u_match (
    .display       (bus.DISPLAY),
    .pw            (bus.PW),
    .pw_temp       (bus.PW_TEMP),
    .pw_temp_valid (bus.PW_TEMP_VALID),
    .perm_hit      (perm_hit),
    .temp_hit      (temp_hit),
    .hit_idx       (hit_idx)
  );

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state     <= IDLE;
      wrong_cnt <= '0;
      match_idx <= '0;
      lock_cnt  <= '0;
      temp_rst  <= 1'b0;
    end else begin
      state     <= state_nx;
      wrong_cnt <= wrong_nx;
      match_idx <= match_nx;
      lock_cnt  <= lock_nx;
      temp_rst  <= temp_rst_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    wrong_nx    = wrong_cnt;
    match_nx    = match_idx;
    lock_nx     = lock_cnt;
    temp_rst_nx = 1'b0;
    unique case (state)
      IDLE: begin
        // CLOSE_SENSOR is irrelevant here, so STAR alone decides.
        if (bus.STAR) begin
          if (perm_hit) begin
            state_nx = OPEN;
            wrong_nx = '0;
            match_nx = hit_idx;
          end else if (temp_hit) begin
            state_nx    = OPEN;
            wrong_nx    = '0;
            match_nx    = IW'(N_PW);
            temp_rst_nx = 1'b1;
          end else if (wrong_cnt == CW'(MAX_TRIES - 1)) begin
            state_nx = ALARM;
            wrong_nx = '0;
          end else begin
            wrong_nx = wrong_cnt + CW'(1);
          end
        end
      end
      OPEN: if (bus.CLOSE_SENSOR) state_nx = IDLE;
      ALARM: begin
        if (bus.ALERT_OFF) begin
          if (LOCKOUT_CYCLES == 0) begin
            state_nx = IDLE;
          end else begin
            state_nx = LOCKOUT;
            lock_nx  = LW'(LOCKOUT_CYCLES);
          end
        end
      end
      LOCKOUT: begin
        // Leaving on a count of 1 gives exactly LOCKOUT_CYCLES cycles here.
        if (lock_cnt <= LW'(1)) begin
          state_nx = IDLE;
          lock_nx  = '0;
        end else begin
          lock_nx = lock_cnt - LW'(1);
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    bus.CORRECT       = (state == OPEN);
    bus.ALERT         = (state == ALARM);
    bus.LOCKED_OUT    = (state == LOCKOUT);
    bus.PW_TEMP_RESET = temp_rst;
    bus.MATCH_IDX     = match_idx;
    bus.WRONG_CNT     = wrong_cnt;
  end

endmodule

// File: doc/pw_verify.md
# pw_verify

Parametrised password verification engine for the digital door lock, sitting between the keypad/display path and the door actuator/alarm logic. It compares the entered digit string against N_PW permanent passwords and one optional one-shot temporary password. It counts consecutive failures, raises an alarm after MAX_TRIES failures, and enforces a timed lockout after the alarm is acknowledged. It replaces the fixed 16-bit, single-password, hard-coded-five-tries comparator with an explicit state machine.

## Interface
Parameters:
- DIGITS, 4: BCD digits per password. Derived W = 4*DIGITS.
- N_PW, 2: number of permanent password slots, minimum 1.
- MAX_TRIES, 5: consecutive wrong entries that trigger ALARM, minimum 1.
- LOCKOUT_CYCLES, 1000: CLK cycles of lockout after ALERT_OFF. 0 means no lockout.

Ports:
- CLK  in  1  system clock, all logic on rising edge.
- RST_N  in  1  synchronous, active-low reset.
- STAR  in  1  compare request ('*' key). Sampled each cycle; one request per high cycle.
- DISPLAY  in  W  entered digits.
- PW  in  N_PW*W  permanent passwords; slot k is PW[k*W +: W].
- PW_TEMP  in  W  temporary password.
- PW_TEMP_VALID  in  1  temporary password armed.
- CLOSE_SENSOR  in  1  door closed indication.
- ALERT_OFF  in  1  alarm acknowledge.
- CORRECT  out  1  door unlocked (high in OPEN).
- ALERT  out  1  alarm (high in ALARM).
- LOCKED_OUT  out  1  high in LOCKOUT.
- PW_TEMP_RESET  out  1  one-cycle pulse: temporary password consumed.
- MATCH_IDX  out  $clog2(N_PW+1)  matching slot of last success; N_PW means temporary.
- WRONG_CNT  out  $clog2(MAX_TRIES+1)  current consecutive failure count.

## Operation
- States: IDLE, OPEN, ALARM, LOCKOUT. All outputs are registered and decoded from state and counters.
- Match: perm_hit = any slot equals DISPLAY; the lowest-index hit sets MATCH_IDX. temp_hit = PW_TEMP_VALID && DISPLAY == PW_TEMP. A permanent hit takes priority over a temp hit.
- IDLE, STAR with perm_hit: go to OPEN, WRONG_CNT=0, MATCH_IDX=slot.
- IDLE, STAR with temp_hit only: go to OPEN, WRONG_CNT=0, MATCH_IDX=N_PW, pulse PW_TEMP_RESET.
- IDLE, STAR with no hit: WRONG_CNT+1.
  - If the new count equals MAX_TRIES: go to ALARM, WRONG_CNT=0.
- OPEN: STAR ignored. CLOSE_SENSOR=1 returns to IDLE.
- ALARM: STAR and CLOSE_SENSOR ignored. ALERT_OFF=1 loads the lockout counter with LOCKOUT_CYCLES and goes to LOCKOUT, or goes directly to IDLE if LOCKOUT_CYCLES=0.
- LOCKOUT: STAR ignored (not counted). The counter decrements each cycle; at 1 it goes to IDLE.
- ALERT_OFF outside ALARM has no effect. CLOSE_SENSOR outside OPEN has no effect.
- Simultaneous STAR and CLOSE_SENSOR in IDLE: STAR is evaluated and CLOSE_SENSOR is ignored.
- MATCH_IDX holds its value until the next success.
- Reset: state=IDLE; CORRECT, ALERT, LOCKED_OUT and PW_TEMP_RESET = 0; WRONG_CNT=0; MATCH_IDX=0; lockout counter=0. Reset mid-OPEN, mid-ALARM or mid-LOCKOUT returns to IDLE, clears the failure history and clears the alarm.

## Timing
- Latency 1: STAR sampled at edge n; CORRECT, ALERT, PW_TEMP_RESET and WRONG_CNT update at edge n+1.
- PW_TEMP_RESET is high for exactly one cycle per temp success.
- STAR held high in IDLE for k cycles with a wrong code counts k failures.
- Lockout duration: LOCKED_OUT is high for exactly LOCKOUT_CYCLES cycles, starting the cycle after ALERT_OFF is sampled.
- CLOSE_SENSOR sampled at edge n in OPEN: CORRECT=0 from edge n+1.
- Lockout counter width: $clog2(LOCKOUT_CYCLES+1), saturating at 0.
- Compare path is combinational in a single cycle; no pipelining at the default W=16.

## Structure
- Package pw_verify_pkg holds:
  - state enum (IDLE, OPEN, ALARM, LOCKOUT);
  - BCD_DIGIT_W = 4;
  - a function computing index width.
- Sub-module pw_match (combinational): inputs DISPLAY, PW bus, PW_TEMP, PW_TEMP_VALID; outputs perm_hit, temp_hit, hit_idx. Parametrised by DIGITS and N_PW, and reusable by the password-change block.
- pw_verify holds the FSM, failure counter and lockout counter.

## Test plan
Configuration: DIGITS=4, N_PW=2, PW={16'h5678,16'h1234}, PW_TEMP=16'h9999, MAX_TRIES=3, LOCKOUT_CYCLES=4.
- Permanent success: DISPLAY=1234, STAR one cycle → next cycle CORRECT=1, MATCH_IDX=0, WRONG_CNT=0. CLOSE_SENSOR → CORRECT=0 one cycle later.
- Temporary one-shot: PW_TEMP_VALID=1, DISPLAY=9999, STAR → CORRECT=1, MATCH_IDX=2, PW_TEMP_RESET high exactly one cycle. Repeat with PW_TEMP_VALID=0 → WRONG_CNT=1, CORRECT=0.
- Alarm: three STAR pulses with DISPLAY=0000 → WRONG_CNT 1, 2, then ALERT=1 and WRONG_CNT=0. STAR with DISPLAY=1234 during ALARM → no change.
- Lockout: ALERT_OFF in ALARM → ALERT=0, LOCKED_OUT=1 for exactly 4 cycles, STAR ignored. Then IDLE, and DISPLAY=5678 with STAR → CORRECT=1, MATCH_IDX=1.
- Failure reset: two wrong entries, then DISPLAY=1234 with STAR → WRONG_CNT=0. Three further wrong entries are needed to alarm.
- Reset and corners: RST_N=0 during LOCKOUT → all outputs 0 next cycle. STAR together with CLOSE_SENSOR in IDLE with a correct code → OPEN.
